// File: rtl/add_seq_pkg.sv
// Shared widths and FSM state encoding for the sequential 32-bit adder.
package add_seq_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_e;

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a second lookahead
// level computing the group carries directly from cin_i.
module cla_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;
    logic [15:0] c;

    always_comb begin
        p = a_i ^ b_i;
        g = a_i & b_i;

        for (int j = 0; j < 4; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end

        // Group carries are flattened so no carry ripples between groups.
        gc[0] = cin_i;
        gc[1] = gg[0] | (gp[0] & cin_i);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin_i);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);

        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j]   | (p[4*j]   & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])   | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end

        sum_o  = p ^ c;
        cout_o = gc[4];
    end

endmodule

// File: rtl/add_seq_32bit.sv
// Sequential 32-bit adder reusing one 16-bit CLA for the low then high half.
// Optional ovf output (signed overflow) is enabled by defining ADD_SEQ_OVF_EN.
module add_seq_32bit
    import add_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              carry_start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              ready,
    output logic [WORD_W-1:0] sum,
    output logic              carry_out,
    output logic              done
`ifdef ADD_SEQ_OVF_EN
    ,
    output logic              ovf
`endif
);

    state_e              state_q;
    state_e              state_d;
    logic [WORD_W-1:0]   a_q;
    logic [WORD_W-1:0]   b_q;
    logic                cin_q;
    logic [HALF_W-1:0]   lo_sum_q;
    logic                carry_q;
    logic [WORD_W-1:0]   sum_q;
    logic                co_q;
    logic                done_q;

    logic [HALF_W-1:0]   cla_a;
    logic [HALF_W-1:0]   cla_b;
    logic                cla_cin;
    logic [HALF_W-1:0]   cla_sum;
    logic                cla_cout;

    // Handshake: a request is taken on any rising edge where start=1 and
    // ready=1 (IDLE); start is a don't-care whenever ready=0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LO;
            LO:      state_d = HI;
            HI:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The single adder sees the high halves and the stored carry only in HI.
    always_comb begin
        if (state_q == HI) begin
            cla_a   = a_q[WORD_W-1:HALF_W];
            cla_b   = b_q[WORD_W-1:HALF_W];
            cla_cin = carry_q;
        end else begin
            cla_a   = a_q[HALF_W-1:0];
            cla_b   = b_q[HALF_W-1:0];
            cla_cin = cin_q;
        end
    end

    cla_16bit u_cla (
        .a_i    (cla_a),
        .b_i    (cla_b),
        .cin_i  (cla_cin),
        .sum_o  (cla_sum),
        .cout_o (cla_cout)
    );

`ifdef ADD_SEQ_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            lo_sum_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            co_q     <= 1'b0;
            done_q   <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        cin_q <= carry_start;
                    end
                end
                LO: begin
                    lo_sum_q <= cla_sum;
                    carry_q  <= cla_cout;
                end
                HI: begin
                    sum_q  <= {cla_sum, lo_sum_q};
                    co_q   <= cla_cout;
                    done_q <= 1'b1;
`ifdef ADD_SEQ_OVF_EN
                    ovf_q  <= (a_q[WORD_W-1] == b_q[WORD_W-1]) &&
                              (cla_sum[HALF_W-1] != a_q[WORD_W-1]);
`endif
                end
                default: ;
            endcase
        end
    end

    assign ready     = (state_q == IDLE);
    assign sum       = sum_q;
    assign carry_out = co_q;
    assign done      = done_q;
`ifdef ADD_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: doc/add_seq_32bit.md
ADD_SEQ_32BIT -- requirements
Module: add_seq_32bit

Interface
REQ-001 Parameters SHALL be none; widths are fixed by the shared package.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; accepted only on a clk edge where ready=1.
REQ-005 carry_start  input  1  carry into bit 0, sampled with start.
REQ-006 a  input  32  operand A, sampled with start.
REQ-007 b  input  32  operand B, sampled with start.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 sum  output  32  registered result of a+b+carry_start.
REQ-010 carry_out  output  1  registered carry out of bit 31.
REQ-011 done  output  1  one-cycle pulse marking sum/carry_out valid and newly updated.

Function
REQ-012 The block SHALL use one 16-bit CLA twice per operation: low halves first, then high halves.
REQ-013 The FSM SHALL have exactly three states: IDLE, LO, HI.
REQ-014 IDLE: ready=1; start=1 SHALL latch a, b and carry_start into internal registers and move to LO; start=0 stays in IDLE.
REQ-015 LO: the CLA SHALL add latched a[15:0], b[15:0] and carry_start; the edge leaving LO SHALL store the low sum in an internal register and the carry in a carry register, then go to HI.
REQ-016 HI: the CLA SHALL add latched a[31:16], b[31:16] and the carry register; the edge leaving HI SHALL write sum[31:0] and carry_out together, assert done for one cycle and go to IDLE.
REQ-017 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+2.
REQ-018 ready SHALL be 0 in LO and HI; start in those states SHALL be ignored, with no effect on latched operands.
REQ-019 sum and carry_out SHALL change only at the HI exit edge and hold their values otherwise, including during a following operation.
REQ-020 A start in the cycle where done=1 SHALL be accepted (state is IDLE); back-to-back throughput is one result per 3 cycles.
REQ-021 Arithmetic SHALL be unsigned modulo 2^32; carry_out is bit 32 of the true sum.

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, sum=0, carry_out=0, done=0, and all internal operand and carry registers to 0; it takes priority over start.
REQ-023 rst during LO or HI SHALL abort the operation: no done pulse, and sum keeps its reset value of 0.
REQ-024 After rst deasserts, ready SHALL be 1 in the first cycle.

Configuration
REQ-025 Macro ADD_SEQ_OVF_EN, when defined, SHALL add output port ovf (1 bit): signed two's-complement overflow, a[31]==b[31] and sum[31]!=a[31]. It is registered and updated together with sum, and reset to 0.
REQ-026 When ADD_SEQ_OVF_EN is undefined, the ovf port and its logic SHALL be absent, with no other behavioural difference.

Structure
REQ-027 Shared package add_seq_pkg SHALL hold WORD_W=32, HALF_W=16 and the state encoding type (IDLE, LO, HI).
REQ-028 The datapath SHALL instantiate exactly one cla_16bit sub-module, with operands muxed by state; no second adder.

Verification
REQ-029 a=0x0000FFFF, b=0x00000001, carry_start=0 -> sum=0x00010000, carry_out=0; done exactly 2 cycles after the start edge; carry crosses the half boundary.
REQ-030 a=0xFFFFFFFF, b=0x00000000, carry_start=1 -> sum=0x00000000, carry_out=1.
REQ-031 start=1 with a=5, b=6, then start=1 with a=100, b=100 during LO -> single result sum=0x0000000B, no second done.
REQ-032 rst=1 while in LO -> next cycle: ready=1, sum=0, carry_out=0, and no done in the following 4 cycles.
REQ-033 Back-to-back: 0x12345678+0x11111111, then start in the done cycle with 0x80000000+0x80000000 -> sums 0x23456789/co=0, then 0x00000000/co=1, with done pulses 3 cycles apart.
REQ-034 With ADD_SEQ_OVF_EN: 0x7FFFFFFF+0x00000001 -> sum=0x80000000, ovf=1; 0xFFFFFFFF+0x00000001 -> ovf=0, carry_out=1.
